// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: scans two captured operands LSB-first,
// one bit per clock, so the most significant differing bit decides the result.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             done,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {RES_EQ, RES_LT, RES_GT} res_t;

  state_t           state_q;
  res_t             res_q;
  res_t             res_d;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             done_q;
  logic             less_q;
  logic             equal_q;
  logic             greater_q;
  logic             last_bit;

  // A differing bit always overwrites the running result; later (higher) bits win.
  always_comb begin
    res_d = res_q;
    if (sa_q[0] && !sb_q[0]) begin
      res_d = RES_GT;
    end else if (!sa_q[0] && sb_q[0]) begin
      res_d = RES_LT;
    end
  end

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      res_q     <= RES_EQ;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q    <= A;
            sb_q    <= B;
            cnt_q   <= '0;
            res_q   <= RES_EQ;
            ready_q <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          res_q <= res_d;
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            less_q    <= (res_d == RES_LT);
            equal_q   <= (res_d == RES_EQ);
            greater_q <= (res_d == RES_GT);
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign less    = less_q;
  assign equal   = equal_q;
  assign greater = greater_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: directed WIDTH=8 scenarios plus a
// randomized WIDTH=16 run against a plain-arithmetic reference model.
module tb_serial_magnitude_comparator;

  logic        clk;
  logic        rst_n;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        ready8, done8, less8, equal8, greater8;
  logic        ready16, done16, less16, equal16, greater16;

  int checks = 0;
  int errors = 0;

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
    .ready(ready8), .done(done8), .less(less8), .equal(equal8), .greater(greater8)
  );

  serial_magnitude_comparator #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16),
    .ready(ready16), .done(done16), .less(less16), .equal(equal16), .greater(greater16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {less, equal, greater} from ordinary unsigned comparison.
  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
    if (a < b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  // Wait for ready, issue one comparison, return cycles from acceptance to done (-1 on timeout).
  task automatic do_cmp8(input logic [7:0] a, input logic [7:0] b, output int lat);
    for (int n = 0; n < 40 && !ready8; n++) begin
      @(posedge clk); #1;
    end
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done8) begin lat = n; break; end
    end
  endtask

  task automatic do_cmp16(input logic [15:0] a, input logic [15:0] b, output int lat);
    for (int n = 0; n < 40 && !ready16; n++) begin
      @(posedge clk); #1;
    end
    start16 = 1'b1; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done16) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (ready8 !== 1'b1 || done8 !== 1'b0 || {less8, equal8, greater8} !== 3'b000) begin
      errors++;
      $display("FAIL reset8: ready=%b done=%b leg=%b, required ready=1 done=0 leg=000",
               ready8, done8, {less8, equal8, greater8});
    end
    checks++;
    if (ready16 !== 1'b1 || done16 !== 1'b0 || {less16, equal16, greater16} !== 3'b000) begin
      errors++;
      $display("FAIL reset16: ready=%b done=%b leg=%b, required ready=1 done=0 leg=000",
               ready16, done16, {less16, equal16, greater16});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_equal;
    int lat;
    do_cmp8(8'hA5, 8'hA5, lat);
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL eq_latency: got %0d, required 8", lat);
    end
    checks++;
    if ({less8, equal8, greater8} !== 3'b010) begin
      errors++; $display("FAIL eq_result: leg=%b, required 010", {less8, equal8, greater8});
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || ready8 !== 1'b1) begin
      errors++; $display("FAIL done_pulse: done=%b ready=%b, required done=0 ready=1", done8, ready8);
    end
  endtask

  task automatic test_override;
    int lat;
    do_cmp8(8'h01, 8'h02, lat);
    checks++;
    if (lat !== 8 || {less8, equal8, greater8} !== 3'b100) begin
      errors++; $display("FAIL ovr_01_02: lat=%0d leg=%b, required lat=8 leg=100", lat, {less8, equal8, greater8});
    end
    do_cmp8(8'h80, 8'h7F, lat);
    checks++;
    if (lat !== 8 || {less8, equal8, greater8} !== 3'b001) begin
      errors++; $display("FAIL ovr_80_7F: lat=%0d leg=%b, required lat=8 leg=001", lat, {less8, equal8, greater8});
    end
  endtask

  task automatic test_extremes;
    int lat;
    int bad;
    do_cmp8(8'hFF, 8'h00, lat);
    checks++;
    if (lat !== 8 || {less8, equal8, greater8} !== 3'b001) begin
      errors++; $display("FAIL ext_FF_00: lat=%0d leg=%b, required lat=8 leg=001", lat, {less8, equal8, greater8});
    end
    // Previous result must hold through IDLE and the whole next scan.
    repeat (3) begin @(posedge clk); #1; end
    start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    bad = 0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      if (done8) begin lat = n - 1; break; end
      if ({less8, equal8, greater8} !== 3'b001) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL ext_hold: %0d cycles with changed result, required 0", bad);
    end
    checks++;
    if (lat !== 8 || {less8, equal8, greater8} !== 3'b100) begin
      errors++; $display("FAIL ext_00_FF: lat=%0d leg=%b, required lat=8 leg=100", lat, {less8, equal8, greater8});
    end
  endtask

  task automatic test_protocol;
    int not_ready;
    int lat;
    int accepted;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
    @(posedge clk); #1;
    start8 = 1'b0;
    not_ready = 0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      // Scramble operands and pulse start while busy.
      a8 = 8'hFF; b8 = 8'h00;
      start8 = n[0];
      @(posedge clk); #1;
      if (done8) begin lat = n; break; end
      if (ready8 !== 1'b0) not_ready++;
    end
    checks++;
    if (not_ready != 0 || lat !== 8) begin
      errors++; $display("FAIL busy_ready: %0d ready cycles, lat=%0d, required 0 and 8", not_ready, lat);
    end
    checks++;
    if ({less8, equal8, greater8} !== 3'b100) begin
      errors++; $display("FAIL captured_ops: leg=%b, required 100", {less8, equal8, greater8});
    end
    // start during DONE must not be accepted.
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    accepted = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready8 !== 1'b1) accepted++;
    end
    checks++;
    if (accepted != 0) begin
      errors++; $display("FAIL done_start_ignored: %0d busy cycles, required 0", accepted);
    end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    logic [2:0] exp_q[$];
    int cyc;
    int done_cnt;
    logic pr;
    logic [2:0] exp;
    for (int n = 0; n < 40 && !ready8; n++) begin
      @(posedge clk); #1;
    end
    cyc = 0;
    done_cnt = 0;
    start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      pr = ready8;
      @(posedge clk); #1;
      cyc++;
      if (pr) begin
        acc.push_back(cyc);
        exp_q.push_back(ref_cmp(32'(a8), 32'(b8)));
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      if (done8 && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        done_cnt++;
        checks++;
        if ({less8, equal8, greater8} !== exp || cyc != 9 + 10 * (done_cnt - 1)) begin
          errors++; $display("FAIL b2b_result: cyc=%0d leg=%b, required cyc=%0d leg=%b",
                             cyc, {less8, equal8, greater8}, 9 + 10 * (done_cnt - 1), exp);
        end
      end
    end
    start8 = 1'b0;
    checks++;
    if (acc.size() != 4 || done_cnt != 4) begin
      errors++; $display("FAIL b2b_count: %0d acceptances %0d dones, required 4 and 4", acc.size(), done_cnt);
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (acc[j] != 1 + 10 * j) begin
          errors++; $display("FAIL b2b_spacing: acceptance %0d at cycle %0d, required %0d", j, acc[j], 1 + 10 * j);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int bad;
    for (int n = 0; n < 40 && !ready8; n++) begin
      @(posedge clk); #1;
    end
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (ready8 !== 1'b0 || {less8, equal8, greater8} === 3'b000) begin
      errors++; $display("FAIL pre_abort: ready=%b leg=%b, required ready=0 and a held result",
                         ready8, {less8, equal8, greater8});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready8 !== 1'b1 || done8 !== 1'b0 || {less8, equal8, greater8} !== 3'b000) begin
      errors++; $display("FAIL async_abort: ready=%b done=%b leg=%b, required 1 0 000",
                         ready8, done8, {less8, equal8, greater8});
    end
    start8 = 1'b1; a8 = 8'h00; b8 = 8'h01;
    @(posedge clk); #1;
    start8 = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 !== 1'b0 || ready8 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL no_done_after_abort: %0d bad cycles, required 0", bad);
    end
    do_cmp8(8'h10, 8'h20, lat);
    checks++;
    if (lat !== 8 || {less8, equal8, greater8} !== 3'b100) begin
      errors++; $display("FAIL post_reset: lat=%0d leg=%b, required lat=8 leg=100", lat, {less8, equal8, greater8});
    end
  endtask

  task automatic test_random16;
    int lat;
    logic [15:0] a, b;
    logic [2:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(7) == 0) ? a : 16'($urandom);
      exp = ref_cmp(32'(a), 32'(b));
      do_cmp16(a, b, lat);
      checks++;
      if (lat !== 16 || $countones({less16, equal16, greater16}) != 1 ||
          {less16, equal16, greater16} !== exp) begin
        errors++; $display("FAIL rand16 #%0d A=%h B=%h: lat=%0d leg=%b, required lat=16 leg=%b",
                           i, a, b, lat, {less16, equal16, greater16}, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    test_reset();
    test_equal();
    test_override();
    test_extremes();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    test_random16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Bit-serial unsigned magnitude comparator. It captures two WIDTH-bit operands on a start handshake and scans them LSB-first, one bit per clock. Any higher bit that differs overrides the decision from the lower bits. It is the sequential, opposite-scan-direction counterpart of the combinational MSB-first ripple comparator, for area-constrained paths where a result after WIDTH cycles is acceptable. Results are registered and held until the next comparison completes.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request a comparison; accepted only on a rising edge where start=1 and ready=1.
- A  input  WIDTH  first operand, unsigned; sampled only on acceptance.
- B  input  WIDTH  second operand, unsigned; sampled only on acceptance.
- ready  output  1  high only in IDLE.
- done  output  1  single-cycle pulse; the result outputs are valid from this cycle onward.
- less  output  1  A < B for the last completed comparison.
- equal  output  1  A == B for the last completed comparison.
- greater  output  1  A > B for the last completed comparison.

## Operation
- States: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE:
  - ready=1.
  - On start=1, copy A and B into internal shift registers sa/sb, clear the bit counter, and set the internal running result to equal.
  - Go to SCAN.
- SCAN:
  - ready=0.
  - Each edge examines sa[0] and sb[0]:
    - sa[0]=1, sb[0]=0 → running result = greater.
    - sa[0]=0, sb[0]=1 → running result = less.
    - equal bits → running result unchanged.
  - On the same edge, shift sa/sb right by one and increment the counter.
  - On the edge that processes bit WIDTH-1, load less/equal/greater from the final running result (including that bit's decision), set done=1, and go to DONE.
- DONE:
  - ready=0 and done=1 for exactly this one cycle.
  - Next edge clears done and returns to IDLE.
- Result outputs:
  - Exactly one of less/equal/greater is high after the first completed comparison.
  - They change only on the SCAN→DONE edge and are held through IDLE and the next SCAN.
- start is ignored while ready=0; no queuing. Changes on A/B after acceptance have no effect.
- Counter width is $clog2(WIDTH). The counter never wraps within a scan because it is cleared on acceptance.

## Timing
- Reset values: ready=1, done=0, less=0, equal=0, greater=0; state=IDLE; sa, sb, counter and running result cleared.
- Accept on edge k:
  - Bits 0..WIDTH-1 are processed on edges k+1..k+WIDTH.
  - done=1 and results are valid after edge k+WIDTH.
  - ready=1 again after edge k+WIDTH+1.
- Latency from acceptance to done: WIDTH cycles. Minimum issue interval: WIDTH+2 cycles.
- Back-to-back: if start is held high, the next acceptance occurs on the first edge where ready=1, i.e. edge k+WIDTH+2.
- rst_n asserted mid-SCAN or in DONE:
  - Abort immediately, asynchronously. All outputs take their reset values, including clearing any held result.
  - No done pulse for the aborted comparison.
  - After rst_n deasserts, the first edge may accept a new start.
- start together with rst_n low: ignored.

## Test plan
- After reset, check ready=1 and done/less/equal/greater=0. Start with A=8'hA5, B=8'hA5 → done exactly 8 cycles after acceptance, with equal=1, less=0, greater=0.
- Higher bit overrides lower bit:
  - A=8'h01, B=8'h02 → less=1 (bit0 favours A, bit1 overrides).
  - A=8'h80, B=8'h7F → greater=1.
- Extremes:
  - A=8'hFF, B=8'h00 → greater=1.
  - A=8'h00, B=8'hFF → less=1.
  - Results from each comparison are held unchanged until the next done.
- Protocol checks:
  - Pulse start during SCAN and during DONE → ignored, ready=0 throughout.
  - Change A/B mid-scan → result reflects the captured operands only.
  - Hold start high → acceptances are exactly 10 cycles apart.
- Reset mid-operation: drop rst_n 4 cycles into a scan → outputs zero immediately, no done pulse. Release rst_n and start A=8'h10, B=8'h20 → less=1 after 8 cycles.
- Run a WIDTH=16 instance with 1000 random operand pairs compared against a reference model. Latency must be 16 cycles, and the results must be one-hot and correct.
